// File: rtl/ide_io_sequencer.sv
// IO-controller side sequencer for the IDE task-file / sector-buffer block.
// Turns strobed host commands into task-file transfers, sector streaming and ack cycles.
module ide_io_sequencer #(
   parameter int SECTOR_BYTES = 512,
   parameter int TF_REGS      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] host_cmd,
   input  logic       host_cmd_stb,
   input  logic       host_err,
   output logic       host_busy,
   output logic       host_irq,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   input  logic       ide_req,
   output logic       ide_ack,
   output logic       ide_err,
   output logic [2:0] ide_reg_o_adr,
   input  logic [7:0] ide_reg_o,
   output logic       ide_reg_we,
   output logic [2:0] ide_reg_i_adr,
   output logic [7:0] ide_reg_i,
   output logic [8:0] ide_data_addr,
   input  logic [7:0] ide_data_o,
   output logic [7:0] ide_data_i,
   output logic       ide_data_rd,
   output logic       ide_data_we
);

   localparam logic [8:0] LAST_PTR = 9'(SECTOR_BYTES - 1);
   localparam logic [2:0] LAST_IDX = 3'(TF_REGS - 1);

   localparam logic [2:0] CMD_GET_TF    = 3'd1;
   localparam logic [2:0] CMD_PUT_TF    = 3'd2;
   localparam logic [2:0] CMD_FILL_BUF  = 3'd3;
   localparam logic [2:0] CMD_DRAIN_BUF = 3'd4;
   localparam logic [2:0] CMD_ACK       = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TF_OUT,
      S_TF_IN,
      S_FILL,
      S_DRAIN_RD,
      S_DRAIN_WAIT,
      S_DRAIN_OUT,
      S_ACK
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] idx;
   logic [8:0] ptr;
   logic       req_d;
   logic       req_rise;

   logic       idx_clr;
   logic       idx_inc;
   logic       ptr_clr;
   logic       ptr_inc;
   logic       tx_load_tf;
   logic       tx_load_buf;
   logic       tx_clr;
   logic       irq_clr;
   logic       err_load;

   // Terminal-count tests: transfers stop on the last index instead of wrapping.
   function automatic logic last_idx(input logic [2:0] i);
      return (i == LAST_IDX);
   endfunction

   function automatic logic last_ptr(input logic [8:0] p);
      return (p == LAST_PTR);
   endfunction

   assign req_rise = ide_req & ~req_d;

   always_comb begin
      state_nxt     = state;
      idx_clr       = 1'b0;
      idx_inc       = 1'b0;
      ptr_clr       = 1'b0;
      ptr_inc       = 1'b0;
      tx_load_tf    = 1'b0;
      tx_load_buf   = 1'b0;
      tx_clr        = 1'b0;
      irq_clr       = 1'b0;
      err_load      = 1'b0;
      host_busy     = (state != S_IDLE);
      rx_ready      = 1'b0;
      ide_ack       = 1'b0;
      ide_reg_o_adr = 3'd0;
      ide_reg_we    = 1'b0;
      ide_reg_i_adr = 3'd0;
      ide_reg_i     = 8'd0;
      ide_data_addr = 9'd0;
      ide_data_i    = 8'd0;
      ide_data_rd   = 1'b0;
      ide_data_we   = 1'b0;

      case (state)
         S_IDLE: begin
            if (host_cmd_stb) begin
               case (host_cmd)
                  CMD_GET_TF: begin
                     state_nxt = S_TF_OUT;
                     idx_clr   = 1'b1;
                     irq_clr   = 1'b1;
                  end
                  CMD_PUT_TF: begin
                     state_nxt = S_TF_IN;
                     idx_clr   = 1'b1;
                  end
                  CMD_FILL_BUF: begin
                     state_nxt = S_FILL;
                     ptr_clr   = 1'b1;
                  end
                  CMD_DRAIN_BUF: begin
                     state_nxt = S_DRAIN_RD;
                     ptr_clr   = 1'b1;
                  end
                  CMD_ACK: begin
                     state_nxt = S_ACK;
                     err_load  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         // Byte is captured once when tx_valid rises, then held until the host takes it.
         S_TF_OUT: begin
            ide_reg_o_adr = idx;
            if (!tx_valid) begin
               tx_load_tf = 1'b1;
            end else if (tx_ready) begin
               tx_clr = 1'b1;
               if (last_idx(idx)) state_nxt = S_IDLE;
               else               idx_inc   = 1'b1;
            end
         end

         S_TF_IN: begin
            rx_ready      = 1'b1;
            ide_reg_i_adr = idx;
            if (rx_valid) begin
               ide_reg_we = 1'b1;
               ide_reg_i  = rx_data;
               if (last_idx(idx)) state_nxt = S_IDLE;
               else               idx_inc   = 1'b1;
            end
         end

         S_FILL: begin
            rx_ready      = 1'b1;
            ide_data_addr = ptr;
            if (rx_valid) begin
               ide_data_we = 1'b1;
               ide_data_i  = rx_data;
               if (last_ptr(ptr)) state_nxt = S_IDLE;
               else               ptr_inc   = 1'b1;
            end
         end

         S_DRAIN_RD: begin
            ide_data_addr = ptr;
            ide_data_rd   = 1'b1;
            state_nxt     = S_DRAIN_WAIT;
         end

         // Buffer read data is valid one clock after the read strobe.
         S_DRAIN_WAIT: begin
            ide_data_addr = ptr;
            tx_load_buf   = 1'b1;
            state_nxt     = S_DRAIN_OUT;
         end

         S_DRAIN_OUT: begin
            ide_data_addr = ptr;
            if (tx_ready) begin
               tx_clr = 1'b1;
               if (last_ptr(ptr)) begin
                  state_nxt = S_IDLE;
               end else begin
                  ptr_inc   = 1'b1;
                  state_nxt = S_DRAIN_RD;
               end
            end
         end

         S_ACK: begin
            ide_ack   = 1'b1;
            state_nxt = S_IDLE;
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= 3'd0;
         ptr      <= 9'd0;
         tx_data  <= 8'd0;
         tx_valid <= 1'b0;
         req_d    <= 1'b0;
         host_irq <= 1'b0;
         ide_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         req_d <= ide_req;

         if (idx_clr)      idx <= 3'd0;
         else if (idx_inc) idx <= idx + 3'd1;

         if (ptr_clr)      ptr <= 9'd0;
         else if (ptr_inc) ptr <= ptr + 9'd1;

         if (tx_load_tf) begin
            tx_data  <= ide_reg_o;
            tx_valid <= 1'b1;
         end else if (tx_load_buf) begin
            tx_data  <= ide_data_o;
            tx_valid <= 1'b1;
         end else if (tx_clr) begin
            tx_valid <= 1'b0;
         end

         // A new request edge wins over a simultaneous GET_TF clear.
         if (req_rise)     host_irq <= 1'b1;
         else if (irq_clr) host_irq <= 1'b0;

         if (err_load) ide_err <= host_err;
      end
   end

endmodule

// File: tb/tb_ide_io_sequencer.sv
// Scoreboard bench for ide_io_sequencer with behavioural task-file and sector-buffer models.
module tb_ide_io_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] host_cmd;
   logic       host_cmd_stb;
   logic       host_err;
   logic       host_busy;
   logic       host_irq;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       ide_req;
   logic       ide_ack;
   logic       ide_err;
   logic [2:0] ide_reg_o_adr;
   logic [7:0] ide_reg_o;
   logic       ide_reg_we;
   logic [2:0] ide_reg_i_adr;
   logic [7:0] ide_reg_i;
   logic [8:0] ide_data_addr;
   logic [7:0] ide_data_o;
   logic [7:0] ide_data_i;
   logic       ide_data_rd;
   logic       ide_data_we;

   always #5 clk = ~clk;

   ide_io_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .host_cmd      (host_cmd),
      .host_cmd_stb  (host_cmd_stb),
      .host_err      (host_err),
      .host_busy     (host_busy),
      .host_irq      (host_irq),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .ide_req       (ide_req),
      .ide_ack       (ide_ack),
      .ide_err       (ide_err),
      .ide_reg_o_adr (ide_reg_o_adr),
      .ide_reg_o     (ide_reg_o),
      .ide_reg_we    (ide_reg_we),
      .ide_reg_i_adr (ide_reg_i_adr),
      .ide_reg_i     (ide_reg_i),
      .ide_data_addr (ide_data_addr),
      .ide_data_o    (ide_data_o),
      .ide_data_i    (ide_data_i),
      .ide_data_rd   (ide_data_rd),
      .ide_data_we   (ide_data_we)
   );

   // Peripheral models: task file with combinational read, sector buffer with 1-clk read.
   logic [7:0] tf_mem [0:7];
   logic [7:0] sbuf   [0:511];

   assign ide_reg_o = tf_mem[ide_reg_o_adr];

   always @(posedge clk) begin
      if (ide_reg_we)  tf_mem[ide_reg_i_adr] <= ide_reg_i;
      if (ide_data_we) sbuf[ide_data_addr]   <= ide_data_i;
      if (ide_data_rd) ide_data_o            <= sbuf[ide_data_addr];
   end

   int n_checks = 0;
   int n_errors = 0;
   int tx_hs    = 0;
   int reg_wes  = 0;
   int rd_cnt   = 0;
   int fill_exp = 0;

   logic [7:0]  tx_q [$];
   logic [10:0] we_q [$];

   wire [47:0] all_outs = {host_busy, host_irq, tx_data, tx_valid, rx_ready, ide_ack, ide_err,
                           ide_reg_o_adr, ide_reg_we, ide_reg_i_adr, ide_reg_i, ide_data_addr,
                           ide_data_i, ide_data_rd, ide_data_we};

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, half a period away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (tx_valid && tx_ready) begin
            tx_hs++;
            check("tx_expected", tx_q.size() != 0, 1);
            if (tx_q.size() != 0) check("tx_byte", tx_data, tx_q.pop_front());
         end
         if (ide_reg_we) begin
            reg_wes++;
            check("reg_we_expected", we_q.size() != 0, 1);
            if (we_q.size() != 0) check("reg_write", {ide_reg_i_adr, ide_reg_i}, we_q.pop_front());
         end
         if (ide_data_we) begin
            check("fill_addr", ide_data_addr, fill_exp);
            fill_exp++;
         end
         if (ide_data_rd) rd_cnt++;
         if (ide_reg_we || ide_data_we) check("we_exclusive", ide_reg_we & ide_data_we, 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] c, input logic err);
      host_cmd     = c;
      host_err     = err;
      host_cmd_stb = 1'b1;
      step();
      host_cmd_stb = 1'b0;
      host_cmd     = 3'd0;
      host_err     = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (host_busy && n < budget) begin
         step();
         n++;
      end
      check(tag, host_busy, 0);
   endtask

   task automatic send_rx(input logic [7:0] d);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = d;
      while (!rx_ready && n < 20) begin
         step();
         n++;
      end
      if (n == 20) check("rx_ready_timeout", rx_ready, 1);
      step();
      rx_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) tf_mem[i] = 8'(i);
      reset        = 1'b1;
      host_cmd     = 3'd0;
      host_cmd_stb = 1'b0;
      host_err     = 1'b0;
      tx_ready     = 1'b0;
      rx_data      = 8'd0;
      rx_valid     = 1'b0;
      ide_req      = 1'b0;
      step();
      step();
      check("reset_outputs", all_outs, 0);
      reset = 1'b0;
      step();

      // GET_TF with task file 00..07
      for (int i = 0; i < 8; i++) tx_q.push_back(8'(i));
      tx_hs    = 0;
      tx_ready = 1'b1;
      send_cmd(3'd1, 1'b0);
      check("get_tf_busy", host_busy, 1);
      wait_idle(100, "get_tf_done");
      check("get_tf_handshakes", tx_hs, 8);
      check("get_tf_queue_empty", tx_q.size(), 0);
      tx_ready = 1'b0;

      // PUT_TF A0..A7 with gaps on rx_valid
      reg_wes = 0;
      send_cmd(3'd2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         we_q.push_back({3'(i), 8'(8'hA0 + i)});
         if (i % 3 == 1) step();
         send_rx(8'(8'hA0 + i));
      end
      check("put_tf_busy_drop", host_busy, 0);
      check("put_tf_writes", reg_wes, 8);
      check("put_tf_queue_empty", we_q.size(), 0);

      // rx bytes offered while idle are not consumed
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      check("idle_rx_ready", rx_ready, 0);
      step();
      rx_valid = 1'b0;
      check("idle_no_write", reg_wes, 8);

      // FILL 512 bytes of (i & 0xFF)
      fill_exp = 0;
      send_cmd(3'd3, 1'b0);
      for (int i = 0; i < 512; i++) send_rx(8'(i & 8'hFF));
      check("fill_busy_drop", host_busy, 0);
      check("fill_count", fill_exp, 512);

      // DRAIN with tx_ready toggling and an ide_req pulse mid-transfer
      check("irq_before_req", host_irq, 0);
      for (int i = 0; i < 512; i++) tx_q.push_back(8'(i & 8'hFF));
      tx_hs  = 0;
      rd_cnt = 0;
      send_cmd(3'd4, 1'b0);
      begin
         int n = 0;
         while (host_busy && n < 8000) begin
            tx_ready = n[0];
            ide_req  = (n == 100);
            step();
            if (n == 100) check("irq_set_on_req", host_irq, 1);
            n++;
         end
         ide_req = 1'b0;
      end
      check("drain_done", host_busy, 0);
      check("drain_handshakes", tx_hs, 512);
      check("drain_rd_strobes", rd_cnt, 512);
      check("drain_queue_empty", tx_q.size(), 0);
      check("irq_held", host_irq, 1);
      tx_ready = 1'b0;

      // GET_TF clears irq and returns the bytes written by PUT_TF
      for (int i = 0; i < 8; i++) tx_q.push_back(8'(8'hA0 + i));
      tx_hs    = 0;
      tx_ready = 1'b1;
      send_cmd(3'd1, 1'b0);
      check("irq_cleared", host_irq, 0);
      wait_idle(100, "get_tf2_done");
      check("get_tf2_handshakes", tx_hs, 8);
      tx_ready = 1'b0;

      // ACK with host_err=1 then host_err=0
      send_cmd(3'd5, 1'b1);
      check("ack1_pulse", ide_ack, 1);
      check("ack1_err", ide_err, 1);
      step();
      check("ack1_pulse_end", ide_ack, 0);
      check("ack1_idle", host_busy, 0);
      send_cmd(3'd0, 1'b0);
      step();
      check("err_held", ide_err, 1);
      send_cmd(3'd5, 1'b0);
      check("ack0_pulse", ide_ack, 1);
      check("ack0_err", ide_err, 0);
      step();
      check("ack0_pulse_end", ide_ack, 0);

      // Reset in the middle of a FILL at ptr 0x100, then a fresh FILL from address 0
      fill_exp = 0;
      send_cmd(3'd3, 1'b0);
      for (int i = 0; i < 256; i++) send_rx(8'(i));
      rx_valid = 1'b1;
      rx_data  = 8'hEE;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", all_outs, 0);
      rx_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      fill_exp = 0;
      send_cmd(3'd3, 1'b0);
      for (int i = 0; i < 512; i++) send_rx(8'(i ^ 8'h3C));
      check("refill_busy_drop", host_busy, 0);
      check("refill_count", fill_exp, 512);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
